// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the 4-digit common-anode 7-segment scan driver.
// Fonts are active-low in the order {dp,g,f,e,d,c,b,a}.
package fnd_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [7:0] FONT_OFF  = 8'hFF;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // 0-9 as decimal glyphs, A-F as hex so out-of-range values are still visible
    localparam logic [7:0] FONT_ROM [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic int calc_div(input int clk_hz, input int digit_hz);
        return clk_hz / digit_hz;
    endfunction

    function automatic int calc_cnt_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/fnd_font_decoder.sv
// Combinational 4-bit value to active-low 7-segment glyph lookup.
module fnd_font_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] i_value,
    output logic [7:0] o_font
);

    always_comb begin
        o_font = FONT_ROM[i_value];
    end

endmodule

// File: rtl/fnd_scan_driver.sv
// Time-multiplexed scan of four BCD digits onto a common-anode 7-segment display,
// with per-frame snapshot, leading-zero blanking and anti-ghosting dead time.
module fnd_scan_driver
    import fnd_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int DIGIT_HZ      = 1000,
    parameter int BLANK_CYCLES  = 2,
    parameter int BLANK_LEADING = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_1000_value,
    input  logic [3:0] i_100_value,
    input  logic [3:0] i_10_value,
    input  logic [3:0] i_1_value,
    output logic [3:0] o_fndDigit,
    output logic [7:0] o_fndFont
);

    localparam int DIV   = calc_div(CLK_HZ, DIGIT_HZ);
    localparam int CNT_W = calc_cnt_w(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             first_q, first_d;
    bcd_t [3:0]       snap_q, snap_d;
    logic [3:0]       digit_q, digit_d;
    logic [7:0]       font_q, font_d;

    logic             tick;
    logic             frame_load;
    logic [3:0]       lead_zero;
    bcd_t             sel_value;
    logic [7:0]       sel_font;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            first_q <= 1'b1;
            snap_q  <= '0;
            digit_q <= ANODE_OFF;
            font_q  <= FONT_OFF;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            snap_q  <= snap_d;
            digit_q <= digit_d;
            font_q  <= font_d;
        end
    end

    // Snapshot only at the frame boundary so a digit never tears mid-frame
    always_comb begin
        tick       = (cnt_q == CNT_LAST);
        frame_load = first_q || (tick && (idx_q == 2'd3));
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        idx_d      = tick ? idx_q + 2'd1 : idx_q;
        first_d    = 1'b0;
        snap_d     = frame_load ? {i_1000_value, i_100_value, i_10_value, i_1_value} : snap_q;
    end

    always_comb begin
        lead_zero[3] = (snap_q[3] == 4'd0);
        lead_zero[2] = lead_zero[3] && (snap_q[2] == 4'd0);
        lead_zero[1] = lead_zero[2] && (snap_q[1] == 4'd0);
        lead_zero[0] = 1'b0;
    end

    assign sel_value = snap_q[idx_q];

    fnd_font_decoder u_font (
        .i_value (sel_value),
        .o_font  (sel_font)
    );

    always_comb begin
        digit_d = ANODE_OFF;
        font_d  = FONT_OFF;
        if ((int'(cnt_q) >= BLANK_CYCLES) &&
            !((BLANK_LEADING != 0) && lead_zero[idx_q])) begin
            digit_d = ~(4'b0001 << idx_q);
            font_d  = sel_font;
        end
    end

    assign o_fndDigit = digit_q;
    assign o_fndFont  = font_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Scoreboard bench for fnd_scan_driver with DIV=10, two dead clocks, leading-zero blanking.
module tb_fnd_scan_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] v1000 = 4'd0;
    logic [3:0] v100  = 4'd0;
    logic [3:0] v10   = 4'd0;
    logic [3:0] v1    = 4'd5;
    logic [3:0] dig;
    logic [7:0] fnt;

    int total = 0;
    int bad   = 0;
    int e     = 0;
    logic [15:0] snap_m = '0;
    logic [11:0] sb [$];
    logic [11:0] exp_v;

    always #5 clk = ~clk;

    fnd_scan_driver #(
        .CLK_HZ        (100),
        .DIGIT_HZ      (10),
        .BLANK_CYCLES  (2),
        .BLANK_LEADING (1)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_1000_value (v1000),
        .i_100_value  (v100),
        .i_10_value   (v10),
        .i_1_value    (v1),
        .o_fndDigit   (dig),
        .o_fndFont    (fnt)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at t=%0t: got %h want %h", tag, $time, got, want);
        end
    endtask

    function automatic logic [7:0] font_ref(input logic [3:0] v);
        case (v)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    // cyc = edges since reset release; the state before that edge sets the output after it
    function automatic logic [11:0] expect_out(input int cyc, input logic [15:0] s);
        int         cnt;
        int         k;
        logic       blank;
        logic [3:0] an;
        cnt   = cyc % 10;
        k     = (cyc / 10) % 4;
        blank = (k != 0);
        for (int j = k; j < 4; j++)
            if (s[j*4 +: 4] != 4'd0) blank = 1'b0;
        if (cnt < 2 || blank) return {4'hF, 8'hFF};
        an = ~(4'b0001 << k);
        return {an, font_ref(s[k*4 +: 4])};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            e = 0;
            sb.push_back({4'hF, 8'hFF});
        end else begin
            sb.push_back(expect_out(e, snap_m));
            if (e == 0 || e % 40 == 39) snap_m = {v1000, v100, v10, v1};
            e = e + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            exp_v = sb.pop_front();
            chk("anode", {4'h0, dig}, {4'h0, exp_v[11:8]});
            chk("font", fnt, exp_v[7:0]);
        end
    end

    task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        @(negedge clk);
        v1000 = a; v100 = b; v10 = c; v1 = d;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Park on the negedge just before frame edge number ph
    task automatic wait_phase(input int ph);
        int n;
        n = 0;
        @(negedge clk);
        while ((e % 40) != ph && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("phase", 8'(e % 40), 8'(ph));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cycles(45);

        set_in(4'd1, 4'd2, 4'd3, 4'd4);
        cycles(85);

        set_in(4'd0, 4'd0, 4'd0, 4'd3);
        cycles(45);
        wait_phase(5);
        v1 = 4'd4;
        cycles(50);

        set_in(4'd0, 4'd1, 4'd0, 4'd0);
        cycles(85);

        set_in(4'd0, 4'd0, 4'd0, 4'hC);
        cycles(85);

        set_in(4'hF, 4'hA, 4'd0, 4'd9);
        cycles(85);

        set_in(4'd0, 4'd0, 4'd0, 4'd0);
        cycles(45);

        wait_phase(15);
        rst = 1'b1;
        v1000 = 4'd0; v100 = 4'd0; v10 = 4'd2; v1 = 4'd6;
        @(negedge clk);
        rst = 1'b0;
        cycles(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fnd_scan_driver.md
Name: fnd_scan_driver

Overview:
- Downstream consumer of the four per-digit BCD values from the fan-speed value stage (thousands, hundreds, tens, ones).
- Time-multiplexes them onto the Basys3 4-digit common-anode 7-segment display.
- Generates the digit-scan timebase, snapshots the values once per frame so digits never tear, blanks leading zeros, and inserts anti-ghosting dead time.
- Drives the active-low anode and segment pins directly.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- DIGIT_HZ, 1000, per-digit dwell rate. Dwell length DIV = CLK_HZ/DIGIT_HZ clocks; DIV >= 4 is required.
- BLANK_CYCLES, 2, clocks at the start of each dwell with all anodes off. Must satisfy 0 <= BLANK_CYCLES < DIV.
- BLANK_LEADING, 1, 1 = suppress leading-zero digits; 0 = show all four digits.

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_1000_value  in  4  thousands digit value.
- i_100_value  in  4  hundreds digit value.
- i_10_value  in  4  tens digit value.
- i_1_value  in  4  ones digit value.
- o_fndDigit  out  4  anodes, active-low; bit0 = rightmost (ones), bit3 = thousands.
- o_fndFont  out  8  segments, active-low, order {dp,g,f,e,d,c,b,a}; dp is always off (1).

Behaviour:
- Interface: one clock, i_clk. Reset i_reset is synchronous and active-high; it is sampled only on the rising edge of i_clk.
- Reset values:
  - dwell counter = 0, digit index = 0, snapshot registers = 0, first-load flag = 1.
  - o_fndDigit = 4'b1111, o_fndFont = 8'hFF.
- Dwell counter:
  - Counts 0..DIV-1 and wraps to 0.
  - The cycle where counter == DIV-1 is a tick. On a tick, index advances 0→1→2→3→0.
- Snapshot:
  - All four inputs are copied into snapshot registers on the tick where index wraps 3→0.
  - They are also copied on the first clock after reset deasserts, when the first-load flag is set; the flag then clears.
  - Input changes at any other time are ignored until the next frame. Frame length = 4*DIV clocks.
- Digit select: index k selects snapshot digit k (0 = ones … 3 = thousands).
- Blanking:
  - With BLANK_LEADING = 1, digit k (k >= 1) is blank when it and every higher snapshot digit are 0.
  - The ones digit is never blank.
  - A blank digit drives o_fndDigit = 4'b1111 and o_fndFont = 8'hFF for the whole dwell.
- Dead time: while counter < BLANK_CYCLES, o_fndDigit = 4'b1111 and o_fndFont = 8'hFF.
- Otherwise:
  - o_fndDigit = ~(4'b0001 << index).
  - o_fndFont = font(snapshot[index]).
- Font:
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90.
  - A 88, b 83, C C6, d A1, E 86, F 8E (values >9 are shown as hex so faults are visible).
- Latency: outputs are registered. Outputs in cycle n+1 reflect the counter, index and snapshot state of cycle n.
- Reset mid-frame: takes effect on the next edge. Outputs go dark and the scan restarts at the ones digit with a fresh snapshot.
- Simultaneous input change and snapshot edge: the value sampled at that edge is taken.

Decomposition:
- Package fnd_pkg holds:
  - the 16-entry font constant array and the FONT_OFF = 8'hFF constant;
  - ANODE_OFF = 4'b1111;
  - a function computing DIV and its counter width from CLK_HZ/DIGIT_HZ.
- One combinational sub-module, fnd_font_decoder (4-bit value → 8-bit active-low font), is instantiated once on the selected digit.

Test Plan (bench parameters: CLK_HZ=100, DIGIT_HZ=10 → DIV=10, BLANK_CYCLES=2, BLANK_LEADING=1):
- Reset held 3 clocks, then released with inputs 0,0,0,5:
  - outputs stay 1111/FF through cycle 2 of the first dwell;
  - then o_fndDigit=1110 and o_fndFont=92 for 8 clocks;
  - digits 1..3 stay 1111/FF for their full dwells (leading blank).
- Inputs 1,2,3,4:
  - each frame shows 1110/99, 1101/B0, 1011/A4, 0111/F9 in order;
  - each digit is held for 8 clocks, separated by 2 dark clocks.
- Inputs 0,0,0,3, then i_1_value changes to 4 in the middle of the ones dwell:
  - F9... no: B0 is held for the rest of that frame;
  - 99 appears only after the next 3→0 wrap.
- Inputs 0,1,0,0 (hundreds=1): display reads "100", i.e. ones C0, tens C0, hundreds F9, thousands dark.
- i_1_value=4'hC: ones font is C6.
- Assert i_reset during the tens dwell: next cycle outputs are 1111/FF and the scan resumes at the ones digit with a freshly sampled value.
